// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared funct3 codes, states, region bounds and lane masks for data_mem_port
package data_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] DMEM_BASE_DEF = 32'h0000_5000;
    localparam logic [31:0] DMEM_END_DEF  = 32'h0000_8000;

    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_B    = 4'b0001;
    localparam logic [3:0] MASK_H    = 4'b0011;
    localparam logic [3:0] MASK_W    = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_WR1  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // Unshifted byte mask for the access size; zero for unknown codes.
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: size_mask = MASK_B;
            F3_H, F3_HU: size_mask = MASK_H;
            F3_W:        size_mask = MASK_W;
            default:     size_mask = MASK_NONE;
        endcase
    endfunction

    // Access size minus one, used to find the last byte touched.
    function automatic logic [31:0] size_minus1(input logic [2:0] f3);
        case (f3)
            F3_H, F3_HU: size_minus1 = 32'd1;
            F3_W:        size_minus1 = 32'd3;
            default:     size_minus1 = 32'd0;
        endcase
    endfunction

    // Stores only have B/H/W encodings; unsigned codes are load-only.
    function automatic logic funct3_valid(input logic [2:0] f3, input logic we);
        if (we) begin
            funct3_valid = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            funct3_valid = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                           (f3 == F3_BU) || (f3 == F3_HU);
        end
    endfunction

endpackage

// File: rtl/data_mem_align.sv
// rtl/data_mem_align.sv - combinational lane logic: write masks/data for rows R and R+1, load extract/extend
module data_mem_align
    import data_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_lo,
    input  logic [23:0] rd_hi,
    output logic [3:0]  mask_lo,
    output logic [3:0]  mask_hi,
    output logic [31:0] din_lo,
    output logic [31:0] din_hi,
    output logic [31:0] load_data
);

    logic [7:0]  mask8;
    logic [63:0] din64;
    logic [31:0] field;

    // Shift the size mask and store data across an 8-lane window spanning rows R and R+1.
    always_comb begin
        mask8   = {4'b0000, size_mask(funct3)} << offset;
        din64   = {32'h0, wdata} << {offset, 3'b000};
        mask_lo = mask8[3:0];
        mask_hi = mask8[7:4];
        din_lo  = din64[31:0];
        din_hi  = din64[63:32];
    end

    // Pull the addressed field out of {R+1, R} and extend it per funct3.
    always_comb begin
        case (offset)
            2'd0:    field = rd_lo;
            2'd1:    field = {rd_hi[7:0],  rd_lo[31:8]};
            2'd2:    field = {rd_hi[15:0], rd_lo[31:16]};
            default: field = {rd_hi[23:0], rd_lo[31:24]};
        endcase
        case (funct3)
            F3_B:    load_data = {{24{field[7]}}, field[7:0]};
            F3_H:    load_data = {{16{field[15]}}, field[15:0]};
            F3_W:    load_data = field;
            F3_BU:   load_data = {24'h0, field[7:0]};
            F3_HU:   load_data = {16'h0, field[15:0]};
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_port.sv
// rtl/data_mem_port.sv - RV32I load/store front end to BRAM port A; MISALIGNED_SPLIT_EN enables two-row split accesses
module data_mem_port
    import data_mem_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEF,
    parameter logic [31:0] DMEM_END  = DMEM_END_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    state_t      state, state_nx;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        idle, accept, fault, crossing, load_resp, err_d;
    logic [31:0] rdata_d, row_addr;
    logic [3:0]  mem_we_c, mask_lo, mask_hi;
    logic [31:0] din_lo, din_hi, load_data;
    logic [2:0]  a_f3;
    logic [1:0]  a_off;
    logic [31:0] a_wdata, a_rd_lo;

`ifdef MISALIGNED_SPLIT_EN
    logic [31:0] wdata_q, row_nx_q, rd_lo_q, last_addr;
    logic        capture_lo;
`endif

    assign idle     = (state == ST_IDLE);
    assign accept   = idle & req_valid;
    assign row_addr = {req_addr[31:2], 2'b00};

    // In IDLE the lane logic looks at the live request; afterwards at the latched one.
    assign a_f3  = idle ? req_funct3 : f3_q;
    assign a_off = idle ? req_addr[1:0] : off_q;

`ifdef MISALIGNED_SPLIT_EN
    assign a_wdata   = idle ? req_wdata : wdata_q;
    assign a_rd_lo   = (state == ST_RD1) ? rd_lo_q : mem_dout;
    assign mem_addr  = idle ? row_addr : row_nx_q;
    assign last_addr = req_addr + size_minus1(req_funct3);
`else
    assign a_wdata  = req_wdata;
    assign a_rd_lo  = mem_dout;
    assign mem_addr = row_addr;
`endif

    data_mem_align u_align (
        .funct3    (a_f3),
        .offset    (a_off),
        .wdata     (a_wdata),
        .rd_lo     (a_rd_lo),
        .rd_hi     (mem_dout[23:0]),
        .mask_lo   (mask_lo),
        .mask_hi   (mask_hi),
        .din_lo    (din_lo),
        .din_hi    (din_hi),
        .load_data (load_data)
    );

    // Any lane in row R+1 means the access straddles a row boundary.
    assign crossing = |mask_hi;

    // Fault decision for the request presented in IDLE.
    always_comb begin
        fault = !funct3_valid(req_funct3, req_we) ||
                (req_addr >= DMEM_END) ||
                (req_we && (req_addr < DMEM_BASE));
`ifdef MISALIGNED_SPLIT_EN
        fault = fault || (last_addr >= DMEM_END);
`else
        fault = fault || crossing;
`endif
    end

    // Next-state and bus/response control.
    always_comb begin
        state_nx  = state;
        mem_we_c  = 4'b0000;
        load_resp = 1'b0;
        rdata_d   = 32'h0;
        err_d     = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
        capture_lo = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (fault) begin
                        state_nx  = ST_RESP;
                        load_resp = 1'b1;
                        err_d     = 1'b1;
                    end else if (req_we) begin
                        mem_we_c  = mask_lo;
                        load_resp = 1'b1;
`ifdef MISALIGNED_SPLIT_EN
                        state_nx  = crossing ? ST_WR1 : ST_RESP;
`else
                        state_nx  = ST_RESP;
`endif
                    end else begin
                        state_nx = ST_RD0;
                    end
                end
            end
            ST_RD0: begin
`ifdef MISALIGNED_SPLIT_EN
                if (crossing) begin
                    state_nx   = ST_RD1;
                    capture_lo = 1'b1;
                end else begin
                    state_nx  = ST_RESP;
                    load_resp = 1'b1;
                    rdata_d   = load_data;
                end
`else
                state_nx  = ST_RESP;
                load_resp = 1'b1;
                rdata_d   = load_data;
`endif
            end
`ifdef MISALIGNED_SPLIT_EN
            ST_RD1: begin
                state_nx  = ST_RESP;
                load_resp = 1'b1;
                rdata_d   = load_data;
            end
            ST_WR1: begin
                mem_we_c = mask_hi;
                state_nx = ST_RESP;
            end
`endif
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // State and response registers; reset drops any in-flight request silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (load_resp) begin
                resp_rdata_q <= rdata_d;
                resp_err_q   <= err_d;
            end
        end
    end

    // Latch the request fields needed after the accept cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            f3_q  <= req_funct3;
            off_q <= req_addr[1:0];
`ifdef MISALIGNED_SPLIT_EN
            wdata_q  <= req_wdata;
            row_nx_q <= row_addr + 32'd4;
`endif
        end
    end

`ifdef MISALIGNED_SPLIT_EN
    // Hold row R data while row R+1 is being read.
    always_ff @(posedge clk) begin
        if (capture_lo) begin
            rd_lo_q <= mem_dout;
        end
    end
`endif

    assign mem_we     = rst_n ? mem_we_c : 4'b0000;
    assign mem_din    = idle ? din_lo : din_hi;
    assign req_ready  = idle;
    assign resp_valid = (state == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
